// File: rtl/store_block.sv
// Stores a Tn x Tn block into a row-pitched matrix memory, one element per cycle.
// Define STORE_BLOCK_ACCUM_EN to build the read-modify-write (C += block) variant.
module store_block #(
  parameter int Tn = 4,
  parameter int N  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  block_row,
  input  logic [7:0]  block_col,
  input  logic [15:0] block_mat [0:Tn-1][0:Tn-1],
  output logic [7:0]  waddr,
  output logic [15:0] dout,
  output logic        we,
  output logic [7:0]  raddr,
  input  logic [15:0] din,
  output logic        busy,
  output logic        done
);

  localparam int CW = (Tn > 1) ? $clog2(Tn) : 1;
`ifdef STORE_BLOCK_ACCUM_EN
  localparam int DRAIN_LEN = 2;
`else
  localparam int DRAIN_LEN = 1;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] row_i, col_j;
  logic [1:0]    drain_cnt;
  logic [7:0]    row_q, col_q;
  logic [15:0]   mat_q [0:Tn-1][0:Tn-1];
  logic          done_q, done_set, accept, last;
  logic [7:0]    addr_cur;
  logic [15:0]   elem_cur;
  logic [7:0]    waddr_q;
  logic [15:0]   dout_q;

  assign last     = (row_i == CW'(Tn-1)) && (col_j == CW'(Tn-1));
  assign addr_cur = 8'((int'(row_q) + int'(row_i)) * N + int'(col_q) + int'(col_j));
  assign elem_cur = mat_q[row_i][col_j];

  // The done cycle behaves as idle: a start there is taken immediately.
  always_comb begin
    state_nx = state;
    done_set = 1'b0;
    accept   = start && ((state == IDLE) || ((state == DRAIN) && done_q));
    case (state)
      IDLE:  if (accept) state_nx = RUN;
      RUN: begin
        if (last) begin
          state_nx = DRAIN;
          done_set = (DRAIN_LEN == 1);
        end
      end
      DRAIN: begin
        if (accept) begin
          state_nx = RUN;
        end else if (drain_cnt == 2'd0) begin
          state_nx = IDLE;
          done_set = (DRAIN_LEN > 1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row_i     <= '0;
      col_j     <= '0;
      drain_cnt <= 2'd0;
      done_q    <= 1'b0;
      row_q     <= 8'd0;
      col_q     <= 8'd0;
    end else begin
      state  <= state_nx;
      done_q <= done_set;
      if (accept) begin
        row_i <= '0;
        col_j <= '0;
        row_q <= block_row;
        col_q <= block_col;
      end else if (state == RUN) begin
        if (col_j == CW'(Tn-1)) begin
          col_j <= '0;
          row_i <= row_i + CW'(1);
        end else begin
          col_j <= col_j + CW'(1);
        end
        if (last) drain_cnt <= 2'(DRAIN_LEN-1);
      end else if ((state == DRAIN) && (drain_cnt != 2'd0)) begin
        drain_cnt <= drain_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mat_q <= block_mat;
  end

`ifdef STORE_BLOCK_ACCUM_EN
  logic        v1, v2;
  logic [7:0]  a1, a2, raddr_q;
  logic [15:0] e1, e2;

  // Two-stage pipe aligns address/element with memory read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0;
      a1 <= 8'd0; a2 <= 8'd0;
      e1 <= 16'd0; e2 <= 16'd0;
      raddr_q <= 8'd0;
      waddr_q <= 8'd0;
      dout_q  <= 16'd0;
    end else begin
      v1 <= (state == RUN);
      a1 <= addr_cur;
      e1 <= elem_cur;
      v2 <= v1;
      a2 <= a1;
      e2 <= e1;
      if (state == RUN) raddr_q <= addr_cur;
      if (v2) begin
        waddr_q <= a2;
        dout_q  <= din + e2;
      end
    end
  end

  assign we    = v2;
  assign waddr = v2 ? a2 : waddr_q;
  assign dout  = v2 ? din + e2 : dout_q;
  assign raddr = (state == RUN) ? addr_cur : raddr_q;
`else
  logic din_unused;
  assign din_unused = ^din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q <= 8'd0;
      dout_q  <= 16'd0;
    end else if (state == RUN) begin
      waddr_q <= addr_cur;
      dout_q  <= elem_cur;
    end
  end

  assign we    = (state == RUN);
  assign waddr = we ? addr_cur : waddr_q;
  assign dout  = we ? elem_cur : dout_q;
  assign raddr = 8'd0;
`endif

  assign busy = (state != IDLE) && !done_q;
  assign done = done_q;

endmodule

// File: tb/tb_store_block.sv
// Scoreboard bench for store_block: a driver predicts writes/done from the block
// rules, a negedge monitor compares them against the DUT and a latency-2 memory.
module tb_store_block;
  localparam int TN = 4;
  localparam int NP = 16;
`ifdef STORE_BLOCK_ACCUM_EN
  localparam bit ACC = 1'b1;
  localparam int LAT = 2;
`else
  localparam bit ACC = 1'b0;
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  block_row, block_col;
  logic [15:0] block_mat [0:TN-1][0:TN-1];
  logic [7:0]  waddr, raddr;
  logic [15:0] dout, din;
  logic        we, busy, done;

  store_block #(.Tn(TN), .N(NP)) dut (
    .clk(clk), .rst(rst), .start(start), .block_row(block_row),
    .block_col(block_col), .block_mat(block_mat), .waddr(waddr), .dout(dout),
    .we(we), .raddr(raddr), .din(din), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(int a);
    return (a == 255) ? 16'hFFFF : 16'(a);
  endfunction

  // Memory with 2-cycle read latency
  logic [15:0] mem [0:255];
  logic [15:0] rd1, rd2;
  assign din = rd2;
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 256; a++) mem[a] <= init_word(a);
      rd1 <= 16'd0;
      rd2 <= 16'd0;
    end else begin
      rd1 <= mem[raddr];
      rd2 <= rd1;
      if (we) mem[waddr] <= dout;
    end
  end

  typedef struct {
    int          cyc;
    logic [7:0]  a;
    logic [15:0] e;
  } wr_t;

  wr_t         wq[$];
  int          dq[$];
  logic [15:0] ref_mem [0:255];
  logic [15:0] mat_s [0:TN-1][0:TN-1];
  int          n_checks = 0, n_fail = 0;
  int          busy_until = -1, cur_acc = -1, cur_done = -1;
  bit          final_req = 1'b0, final_ack = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    wr_t         e;
    logic [15:0] exp_d;
    logic [7:0]  last_a;
    logic [15:0] last_d;
    int          dc;
    last_a = 8'd0;
    last_d = 16'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wq.delete();
        dq.delete();
        for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a);
        last_a = 8'd0;
        last_d = 16'd0;
        chk("rst_we", int'(we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_raddr", int'(raddr), 0);
        chk("rst_dout", int'(dout), 0);
      end else begin
        chk("busy", int'(busy), int'(cur_acc >= 0 && cyc > cur_acc && cyc < cur_done));
        if (we) begin
          chk("write_pending", int'(wq.size() > 0), 1);
          if (wq.size() > 0) begin
            e = wq.pop_front();
            exp_d = ACC ? ref_mem[e.a] + e.e : e.e;
            chk("write_cycle", cyc, e.cyc);
            chk("waddr", int'(waddr), int'(e.a));
            chk("dout", int'(dout), int'(exp_d));
            ref_mem[e.a] = exp_d;
          end
          last_a = waddr;
          last_d = dout;
        end else begin
          chk("hold_waddr", int'(waddr), int'(last_a));
          chk("hold_dout", int'(dout), int'(last_d));
        end
        if (done) begin
          chk("done_pending", int'(dq.size() > 0), 1);
          if (dq.size() > 0) begin
            dc = dq.pop_front();
            chk("done_cycle", cyc, dc);
          end
        end
        if (final_req && !final_ack) begin
          chk("writes_left", wq.size(), 0);
          chk("dones_left", dq.size(), 0);
          final_ack = 1'b1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic rand_mat();
    for (int i = 0; i < TN; i++)
      for (int j = 0; j < TN; j++) mat_s[i][j] = 16'($urandom);
  endtask

  // Drives one start pulse; predicts the transfer only if the block would accept it.
  task automatic issue(input int r, input int c);
    int first;
    block_row = 8'(r);
    block_col = 8'(c);
    block_mat = mat_s;
    start = 1'b1;
    if (cyc >= busy_until) begin
      first = cyc + 1 + LAT;
      for (int i = 0; i < TN; i++)
        for (int j = 0; j < TN; j++)
          wq.push_back('{first + i*TN + j, 8'(((r + i) * NP + c + j) % 256), mat_s[i][j]});
      cur_acc = cyc;
      busy_until = first + TN*TN;
      cur_done = busy_until;
      dq.push_back(busy_until);
    end
    step(1);
    start = 1'b0;
    block_row = 8'($urandom);
    block_col = 8'($urandom);
    for (int i = 0; i < TN; i++)
      for (int j = 0; j < TN; j++) block_mat[i][j] = 16'($urandom);
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    start = 1'b0;
    block_row = 8'd0;
    block_col = 8'd0;
    for (int i = 0; i < TN; i++)
      for (int j = 0; j < TN; j++) begin
        block_mat[i][j] = 16'd0;
        mat_s[i][j] = 16'd0;
      end
    step(3);
    rst = 1'b0;
    step(2);

    // all-ones block at origin (accumulate: mem[a] becomes a+1)
    for (int i = 0; i < TN; i++)
      for (int j = 0; j < TN; j++) mat_s[i][j] = 16'd1;
    issue(0, 0);
    wait_cyc(busy_until + 2);

    // 16*i+j at (4,8); second start mid-transfer ignored; wrap block started in done cycle
    for (int i = 0; i < TN; i++)
      for (int j = 0; j < TN; j++) mat_s[i][j] = 16'(16*i + j);
    c0 = cyc;
    issue(4, 8);
    wait_cyc(c0 + 5);
    rand_mat();
    issue(9, 3);
    wait_cyc(busy_until);
    rand_mat();
    mat_s[0][1] = 16'h0002;
    issue(15, 14);
    wait_cyc(busy_until + 1);

    // reset at cycle 7 of a transfer
    rand_mat();
    c0 = cyc;
    issue(1, 2);
    wait_cyc(c0 + 7);
    rst = 1'b1;
    busy_until = -1;
    cur_acc = -1;
    cur_done = -1;
    step(2);
    rst = 1'b0;
    step(1);
    rand_mat();
    issue(2, 3);
    wait_cyc(busy_until + 1);

    // random traffic, including starts while busy
    for (int k = 0; k < 14; k++) begin
      step($urandom_range(0, 12));
      rand_mat();
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
    wait_cyc(busy_until + 4);

    final_req = 1'b1;
    repeat (4) if (!final_ack) step(1);
    if (!final_ack) begin
      $display("FAIL final_check: monitor did not respond");
      $fatal(1, "monitor stalled");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/store_block.md
STORE_BLOCK -- requirements
Module: store_block

Interface
REQ-001 Parameter Tn, default 4: block edge length; the block holds Tn*Tn elements.
REQ-002 Parameter N, default 16: row pitch of the destination matrix memory, in elements.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 start  in  1  one-cycle request to store a block; honoured only in IDLE.
REQ-006 block_row  in  8  top row of the destination block; sampled only on an accepted start.
REQ-007 block_col  in  8  left column of the destination block; sampled only on an accepted start.
REQ-008 block_mat  in  16 x [0:Tn-1][0:Tn-1]  source block; sampled only on an accepted start.
REQ-009 waddr  out  8  memory write address.
REQ-010 dout  out  16  memory write data.
REQ-011 we  out  1  memory write enable.
REQ-012 raddr  out  8  memory read address; used only with accumulate (see Configuration).
REQ-013 din  in  16  memory read data, valid 2 cycles after raddr is presented.
REQ-014 busy  out  1  high from the cycle after an accepted start until done is asserted.
REQ-015 done  out  1  single-cycle completion pulse.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN; reset enters IDLE.
REQ-017 In IDLE with start=1, the block SHALL latch block_row, block_col and all of block_mat into internal registers, then go to RUN; later changes to these inputs SHALL NOT affect the transfer.
REQ-018 start SHALL be ignored in RUN and DRAIN.
REQ-019 RUN SHALL visit (i,j) once per cycle in row-major order, j fastest, for i,j in 0..Tn-1: exactly Tn*Tn cycles, then go to DRAIN.
REQ-020 Address for (i,j) SHALL be (block_row+i)*N + (block_col+j), truncated to 8 bits (modulo 256 wrap, no error flag).
REQ-021 Without accumulate: in RUN, we=1, waddr=address(i,j), dout=latched element (i,j) in the same cycle; DRAIN lasts 1 cycle with we=0.
REQ-022 With accumulate: in RUN, raddr=address(i,j); 2 cycles later we=1, waddr=that same address, dout=(din + element(i,j)) mod 2^16; DRAIN lasts 2 cycles and completes the last 2 writes.
REQ-023 done SHALL pulse for exactly 1 cycle, in the cycle after the final write; the FSM returns to IDLE in that same cycle, and a start in that cycle SHALL be accepted.
REQ-024 When we=0, waddr and dout SHALL hold their previous values and we SHALL NOT glitch.
REQ-025 Latency from the start edge to the first we: 1 cycle without accumulate, 3 cycles with accumulate.
REQ-026 Tn=1 SHALL work: a single write, then done.

Reset
REQ-027 Asserting rst at any time, including mid-transfer, SHALL force IDLE and set we=0, busy=0, done=0, waddr=0, raddr=0, dout=0, and clear all pipeline valid bits; in-flight writes SHALL be discarded.
REQ-028 After rst deasserts, the first start SHALL begin a fresh transfer with no residue.

Configuration
REQ-029 Macro STORE_BLOCK_ACCUM_EN: when defined, read-modify-write accumulation (C += block) per REQ-022 SHALL be compiled in.
REQ-030 When STORE_BLOCK_ACCUM_EN is undefined, the plain store of REQ-021 SHALL apply, raddr SHALL be tied to 0, din SHALL be ignored, and the port list SHALL be unchanged.

Verification
REQ-031 No accum, Tn=4, N=16, block_row=4, block_col=8, block_mat[i][j]=16*i+j; start at cycle 0 -> we high cycles 1..16, waddr 72,73,74,75,88,..,123, dout 0,1,2,3,16,..,51; done at cycle 17 only.
REQ-032 Accum, memory model with latency 2 preloaded with mem[a]=a, block_row=0, block_col=0, all elements=1 -> 16 writes at cycles 3..18, mem[a]=a+1 for a in {0..3,16..19,32..35,48..51}; done at cycle 18's next cycle (19).
REQ-033 Accum overflow: mem word 0xFFFF, element 0x0002 -> written value 0x0001.
REQ-034 start pulsed again at cycle 5 of a transfer with different block_row -> ignored, original addresses continue; start in the done cycle -> new transfer, first we at the next cycle.
REQ-035 rst asserted at cycle 7 of a transfer -> we=0 and busy=0 immediately, no further writes, done never pulses; next start runs a full 16-write transfer.
REQ-036 Wrap: block_row=15, block_col=14, N=16 -> addresses 254,255,0,1 for row 0, then wrap modulo 256 with no error.
